// File: rtl/alu_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared definitions for the ALU issue controller:
//   - state_t  : issue FSM states (IDLE, ISSUE, DRAIN, DONE)
//   - OPMODE_W : width of the ALU operation-mode field
//   - SEW_W    : width of the selected-element-width fields
// ----------------------------------------------------------------------------
package alu_ctrl_pkg;

    localparam int OPMODE_W = 9;
    localparam int SEW_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : alu_ctrl_pkg

// File: rtl/alu_credit_cnt.sv
// ----------------------------------------------------------------------------
// alu_credit_cnt
// Tracks the number of elements currently in flight inside the ALU.
// Each cycle the count moves by +issue_cnt_i - popcount(cmpl_i); issue and
// completion in the same cycle net against each other. Completions that would
// take the count below zero are dropped, so the counter never underflows.
//
// Ports
//   clk         in  : rising-edge clock
//   rst         in  : asynchronous active-high reset (count -> 0)
//   issue_cnt_i in  : number of elements issued this cycle
//   cmpl_i      in  : per-interface completion strobes from the ALU
//   cnt_o       out : current outstanding element count
// ----------------------------------------------------------------------------
module alu_credit_cnt #(
    parameter  int PARALLEL_IF_NUM = 4,
    parameter  int MAX_OUTST       = 16,
    localparam int CNT_W           = $clog2(MAX_OUTST + 1),
    localparam int ISS_W           = $clog2(PARALLEL_IF_NUM + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ISS_W-1:0]           issue_cnt_i,
    input  logic [PARALLEL_IF_NUM-1:0] cmpl_i,
    output logic [CNT_W-1:0]           cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    int               sum;
    int               pop;

    function automatic int popcount(input logic [PARALLEL_IF_NUM-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < PARALLEL_IF_NUM; i++) begin
            c = c + (v[i] ? 1 : 0);
        end
        return c;
    endfunction

    // Completions in excess of what is in flight (including what is being
    // issued this very cycle) are stray and clamp the count at zero.
    always_comb begin
        sum = int'(cnt_q) + int'(issue_cnt_i);
        pop = popcount(cmpl_i);
        if (pop >= sum) begin
            cnt_d = '0;
        end else begin
            cnt_d = CNT_W'(sum - pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : alu_credit_cnt

// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
// Issues the elements of one vector instruction to PARALLEL_IF_NUM parallel
// ALU interfaces. On start the instruction fields are captured; the block then
// issues up to PARALLEL_IF_NUM elements per cycle (one per cycle for
// reductions), respecting write-back backpressure and a limit of MAX_OUTST
// elements in flight. After the last issue it waits for all completions and
// pulses done_o for one cycle.
//
// Optional feature: define ALU_ISSUE_CTRL_ABORT_EN to add abort_i, which stops
// issue in ISSUE and moves to DRAIN on the next cycle.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   start_i           : start pulse, sampled only in IDLE
//   vl_i              : element count of the instruction
//   opmode_i          : ALU operation mode
//   input_sew_i       : input element width code
//   output_sew_i      : output element width code
//   reduction_i       : reduction instruction (serial issue on interface 0)
//   stall_i           : write-back backpressure, blocks issue while high
//   abort_i           : (ALU_ISSUE_CTRL_ABORT_EN only) abandon remaining issue
//   ready_o           : high in IDLE
//   alu_vld_o         : per-interface issue strobes
//   alu_opmode_o      : captured opmode, replicated per interface
//   input_sew_o       : captured input SEW, replicated per interface
//   output_sew_o      : captured output SEW, replicated per interface
//   alu_reduction_o   : captured reduction flag, replicated per interface
//   elem_idx_o        : index of the element on interface 0 this cycle
//   alu_vld_i         : per-interface completion strobes from the ALU
//   done_o            : one-cycle pulse when the instruction completes
// ----------------------------------------------------------------------------
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int PARALLEL_IF_NUM = 4,
    parameter int VL_W            = 12,
    parameter int MAX_OUTST       = 16
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     start_i,
    input  logic [VL_W-1:0]                          vl_i,
    input  logic [OPMODE_W-1:0]                      opmode_i,
    input  logic [SEW_W-1:0]                         input_sew_i,
    input  logic [SEW_W-1:0]                         output_sew_i,
    input  logic                                     reduction_i,
    input  logic                                     stall_i,
`ifdef ALU_ISSUE_CTRL_ABORT_EN
    input  logic                                     abort_i,
`endif
    output logic                                     ready_o,
    output logic [PARALLEL_IF_NUM-1:0]               alu_vld_o,
    output logic [PARALLEL_IF_NUM-1:0][OPMODE_W-1:0] alu_opmode_o,
    output logic [PARALLEL_IF_NUM-1:0][SEW_W-1:0]    input_sew_o,
    output logic [PARALLEL_IF_NUM-1:0][SEW_W-1:0]    output_sew_o,
    output logic [PARALLEL_IF_NUM-1:0]               alu_reduction_o,
    output logic [VL_W-1:0]                          elem_idx_o,
    input  logic [PARALLEL_IF_NUM-1:0]               alu_vld_i,
    output logic                                     done_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int ISS_W = $clog2(PARALLEL_IF_NUM + 1);

    state_t                state_q;
    logic [VL_W-1:0]       vl_q;
    logic [VL_W-1:0]       idx_q;
    logic [OPMODE_W-1:0]   opmode_q;
    logic [SEW_W-1:0]      isew_q;
    logic [SEW_W-1:0]      osew_q;
    logic                  reduction_q;

    logic [CNT_W-1:0]      outst;
    logic [VL_W-1:0]       remaining;
    logic [ISS_W-1:0]      n_cand;
    logic [ISS_W-1:0]      n_iss;
    logic                  can_issue;
    logic                  last_issue;
    logic                  abort_w;

`ifdef ALU_ISSUE_CTRL_ABORT_EN
    assign abort_w = abort_i;
`else
    assign abort_w = 1'b0;
`endif

    // Issue decision: the group size is fixed by what is left of the vector,
    // and the whole group is held back if it would overflow the in-flight
    // limit (no partial groups).
    always_comb begin
        remaining = vl_q - idx_q;
        if (reduction_q) begin
            n_cand = ISS_W'(1);
        end else if (remaining >= VL_W'(PARALLEL_IF_NUM)) begin
            n_cand = ISS_W'(PARALLEL_IF_NUM);
        end else begin
            n_cand = remaining[ISS_W-1:0];
        end

        can_issue = (state_q == ST_ISSUE) && !stall_i && !abort_w &&
                    (remaining != '0) &&
                    ((int'(outst) + int'(n_cand)) <= MAX_OUTST);
        n_iss      = can_issue ? n_cand : '0;
        last_issue = can_issue && (VL_W'(n_cand) == remaining);

        for (int i = 0; i < PARALLEL_IF_NUM; i++) begin
            alu_vld_o[i] = can_issue && (i < int'(n_cand));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vl_q        <= '0;
            idx_q       <= '0;
            opmode_q    <= '0;
            isew_q      <= '0;
            osew_q      <= '0;
            reduction_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        vl_q        <= vl_i;
                        idx_q       <= '0;
                        opmode_q    <= opmode_i;
                        isew_q      <= input_sew_i;
                        osew_q      <= output_sew_i;
                        reduction_q <= reduction_i;
                        // An empty vector has nothing to issue or drain.
                        state_q     <= (vl_i == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (can_issue) begin
                        idx_q <= idx_q + VL_W'(n_iss);
                    end
                    if (last_issue || abort_w) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (outst == '0) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    alu_credit_cnt #(
        .PARALLEL_IF_NUM (PARALLEL_IF_NUM),
        .MAX_OUTST       (MAX_OUTST)
    ) u_credit (
        .clk         (clk),
        .rst         (rst),
        .issue_cnt_i (n_iss),
        .cmpl_i      (alu_vld_i),
        .cnt_o       (outst)
    );

    assign ready_o    = (state_q == ST_IDLE);
    assign done_o     = (state_q == ST_DONE);
    assign elem_idx_o = idx_q;

    always_comb begin
        for (int i = 0; i < PARALLEL_IF_NUM; i++) begin
            alu_opmode_o[i]    = opmode_q;
            input_sew_o[i]     = isew_q;
            output_sew_o[i]    = osew_q;
            alu_reduction_o[i] = reduction_q;
        end
    end

endmodule : alu_issue_ctrl
